// File: rtl/ysyx_24100006_hazard_ctrl_if.sv
// Decode-side hazard bus: stage handshakes and ID operand fields in, issue control out.
// Latency: none, wires only.
// Backpressure: carries stall_id back to the decode stage.
interface ysyx_24100006_hazard_ctrl_if #(
  parameter int AW = 4
);
  logic          id_out_valid;
  logic          id_fire;
  logic          exe_fire;
  logic          mem_fire;
  logic          wb_fire;
  logic          flush;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_ren;
  logic          rs2_ren;
  logic          csr_ren;
  logic [AW-1:0] rd_addr;
  logic          rd_wen;
  logic          rd_is_load;
  logic          csr_wen;
  logic          mem_ldata_valid;
  logic          stall_id;
  logic [1:0]    forwardA;
  logic [1:0]    forwardB;

  // pipeline side: drives handshakes and ID fields, consumes issue control
  modport master (
    output id_out_valid, id_fire, exe_fire, mem_fire, wb_fire, flush,
    output rs1_addr, rs2_addr, rs1_ren, rs2_ren, csr_ren,
    output rd_addr, rd_wen, rd_is_load, csr_wen, mem_ldata_valid,
    input  stall_id, forwardA, forwardB
  );

  // hazard controller side
  modport slave (
    input  id_out_valid, id_fire, exe_fire, mem_fire, wb_fire, flush,
    input  rs1_addr, rs2_addr, rs1_ren, rs2_ren, csr_ren,
    input  rd_addr, rd_wen, rd_is_load, csr_wen, mem_ldata_valid,
    output stall_id, forwardA, forwardB
  );
endinterface

// File: rtl/ysyx_24100006_hazard_ctrl.sv
// Scoreboard hazard controller for ID issue: tracks EXE/MEM/WB destinations, picks forward paths or stalls.
// Latency: stall_id/forwardA/forwardB are combinational (0 cycles) from registered slots and current ID fields.
// Backpressure: slots advance only on stage fires and hold indefinitely otherwise; stall_id holds ID.
// Optional macro YSYX_24100006_HAZARD_PERF_EN adds saturating stall / forwarded-issue counters.
module ysyx_24100006_hazard_ctrl #(
  parameter int NR_GPR = 16
) (
  input logic clk,
  input logic reset,
  ysyx_24100006_hazard_ctrl_if.slave bus
`ifdef YSYX_24100006_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_fwd_cnt
`endif
);

  localparam int AW = $clog2(NR_GPR);

  localparam logic [1:0] FWD_GPR = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // vld covers the GPR write only; csr_w is its own occupancy bit
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    logic          is_load;
    logic          csr_w;
  } slot_t;

  slot_t exe_slot, mem_slot, wb_slot;
  slot_t id_entry;

  logic [2:0] res_a, res_b;
  logic       csr_haz;

  // x0 never becomes a dependency, so it is filtered at capture time
  always_comb begin
    id_entry         = '0;
    id_entry.vld     = bus.rd_wen & (bus.rd_addr != '0);
    id_entry.rd      = bus.rd_addr;
    id_entry.is_load = bus.rd_is_load;
    id_entry.csr_w   = bus.csr_wen;
  end

  // all three slots shift in parallel from their pre-edge values
  always_ff @(posedge clk) begin
    if (!reset) begin
      exe_slot <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      if (bus.id_fire && !bus.flush) exe_slot <= id_entry;
      else if (bus.exe_fire)         exe_slot <= '0;

      if (bus.exe_fire)      mem_slot <= exe_slot;
      else if (bus.mem_fire) mem_slot <= '0;

      if (bus.mem_fire)     wb_slot <= mem_slot;
      else if (bus.wb_fire) wb_slot <= '0;
    end
  end

  // Returns {hazard, fwd}. The youngest producer wins; a stalled source reports GPR select.
  // WB has no bypass: its write lands at the wb_fire edge, so a WB-only match must wait.
  function automatic logic [2:0] resolve(
    input logic          ren,
    input logic [AW-1:0] addr,
    input slot_t         s_exe,
    input slot_t         s_mem,
    input slot_t         s_wb,
    input logic          ldata_vld
  );
    logic [2:0] r;
    r = {1'b0, FWD_GPR};
    if (ren && addr != '0) begin
      if (s_exe.vld && s_exe.rd == addr)
        r = s_exe.is_load ? {1'b1, FWD_GPR} : {1'b0, FWD_EXE};
      else if (s_mem.vld && s_mem.rd == addr)
        r = (s_mem.is_load && !ldata_vld) ? {1'b1, FWD_GPR} : {1'b0, FWD_MEM};
      else if (s_wb.vld && s_wb.rd == addr)
        r = {1'b1, FWD_GPR};
    end
    return r;
  endfunction

  // per-source resolution plus the address-blind CSR check
  always_comb begin
    res_a   = resolve(bus.rs1_ren, bus.rs1_addr, exe_slot, mem_slot, wb_slot, bus.mem_ldata_valid);
    res_b   = resolve(bus.rs2_ren, bus.rs2_addr, exe_slot, mem_slot, wb_slot, bus.mem_ldata_valid);
    csr_haz = bus.csr_ren & (exe_slot.csr_w | mem_slot.csr_w | wb_slot.csr_w);
  end

  assign bus.stall_id = bus.id_out_valid & (res_a[2] | res_b[2] | csr_haz);
  assign bus.forwardA = res_a[1:0];
  assign bus.forwardB = res_b[1:0];

`ifdef YSYX_24100006_HAZARD_PERF_EN
  logic fwd_issue;
  assign fwd_issue = bus.id_fire & ~bus.flush & ((res_a[1:0] != FWD_GPR) | (res_b[1:0] != FWD_GPR));

  // saturating counters: stop at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (bus.stall_id && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (fwd_issue && perf_fwd_cnt != 32'hFFFF_FFFF)      perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100006_hazard_ctrl.sv
// Bench for the ID hazard controller: directed pipeline scenarios plus randomized traffic.
// Reference model keeps in-flight producers as a 3-deep array, youngest first.
// Outputs are sampled 1-2 time units after the rising edge, inputs change just after it.
module tb_ysyx_24100006_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ysyx_24100006_hazard_ctrl_if bus();

`ifdef YSYX_24100006_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
  ysyx_24100006_hazard_ctrl #(.NR_GPR(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
  );
`else
  ysyx_24100006_hazard_ctrl #(.NR_GPR(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int rd;
    bit ld;
    bit csr;
  } ent_t;

  ent_t pipe[3];  // 0 = EXE (youngest), 1 = MEM, 2 = WB
  ent_t empty_e = '{v: 1'b0, rd: 0, ld: 1'b0, csr: 1'b0};

  always @(posedge clk) begin
    ent_t n[3];
    if (!reset) begin
      for (int i = 0; i < 3; i++) n[i] = empty_e;
    end else begin
      n[2] = bus.mem_fire ? pipe[1] : (bus.wb_fire  ? empty_e : pipe[2]);
      n[1] = bus.exe_fire ? pipe[0] : (bus.mem_fire ? empty_e : pipe[1]);
      if (bus.id_fire && !bus.flush)
        n[0] = '{v: bus.rd_wen && bus.rd_addr != 0, rd: int'(bus.rd_addr),
                 ld: bus.rd_is_load, csr: bus.csr_wen};
      else
        n[0] = bus.exe_fire ? empty_e : pipe[0];
    end
    pipe = n;
  end

  function automatic void model_src(input bit ren, input int a, output bit haz, output logic [1:0] fwd);
    haz = 1'b0;
    fwd = 2'b00;
    if (ren && a != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (pipe[i].v && pipe[i].rd == a) begin
          case (i)
            0: if (pipe[i].ld) haz = 1'b1; else fwd = 2'b01;
            1: if (pipe[i].ld && !bus.mem_ldata_valid) haz = 1'b1; else fwd = 2'b10;
            default: haz = 1'b1;
          endcase
          break;
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fires(input bit id, input bit exe, input bit mem, input bit wb);
    bus.id_fire  = id;
    bus.exe_fire = exe;
    bus.mem_fire = mem;
    bus.wb_fire  = wb;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit r1, input int rs2, input bit r2,
                        input int rd, input bit wen, input bit ld);
    bus.id_out_valid = v;
    bus.rs1_addr     = 4'(rs1);
    bus.rs1_ren      = r1;
    bus.rs2_addr     = 4'(rs2);
    bus.rs2_ren      = r2;
    bus.rd_addr      = 4'(rd);
    bus.rd_wen       = wen;
    bus.rd_is_load   = ld;
  endtask

  task automatic clr_inputs();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    fires(0, 0, 0, 0);
    bus.flush           = 1'b0;
    bus.csr_ren         = 1'b0;
    bus.csr_wen         = 1'b0;
    bus.mem_ldata_valid = 1'b0;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.csr_wen = 1'b0;
    fires(0, 1, 1, 1);
    repeat (3) tick();
    fires(0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_id(1, 5, 1, 6, 1, 0, 0, 0);
    bus.csr_ren = 1'b1;
    #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
    bus.csr_ren = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_id(1, 0, 1, 0, 0, 5, 1, 0); fires(1, 0, 0, 0); #1;   // addi x5,x0,1
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL b2b_first: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0); fires(1, 1, 0, 0); #1;   // add x6,x5,x5
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_01_01) begin
      errors++; $display("FAIL b2b_second: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_01_01);
    end
    tick();
    set_id(1, 5, 1, 6, 1, 0, 0, 0); fires(0, 0, 0, 0); #1;   // x5 in MEM, x6 in EXE
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_10_01) begin
      errors++; $display("FAIL b2b_mem_exe: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_10_01);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 0, 0, 7, 1, 1); fires(1, 0, 0, 0); tick();  // lw x7
    set_id(1, 7, 1, 0, 0, 8, 1, 0); fires(0, 0, 0, 0);
    bus.mem_ldata_valid = 1'b0; #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b1_00_00) begin
      errors++; $display("FAIL lu_exe: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b1_00_00);
    end
    fires(0, 1, 0, 0); tick(); fires(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b1_00_00) begin
        errors++; $display("FAIL lu_mem_wait%0d: got %b want %b", k, {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b1_00_00);
      end
      tick();
    end
    bus.mem_ldata_valid = 1'b1; #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_10_00) begin
      errors++; $display("FAIL lu_mem_valid: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_10_00);
    end
    bus.mem_ldata_valid = 1'b0;
    drain();
  endtask

  task automatic test_wb_only();
    set_id(1, 0, 0, 0, 0, 3, 1, 0); fires(1, 0, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    fires(0, 1, 0, 0); tick();
    fires(0, 0, 1, 0); tick();
    fires(0, 0, 0, 0);
    set_id(1, 3, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b1_00_00) begin
        errors++; $display("FAIL wb_wait%0d: got %b want %b", k, {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b1_00_00);
      end
      if (k == 2) fires(0, 0, 0, 1);
      tick();
    end
    fires(0, 0, 0, 0); #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL wb_after: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
  endtask

  task automatic test_x0_csr();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); fires(1, 0, 0, 0); tick();  // writes x0
    fires(0, 0, 0, 0);
    set_id(1, 0, 1, 0, 1, 0, 0, 0); #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL x0_dep: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
    drain();
    set_id(1, 0, 0, 0, 0, 0, 0, 0); bus.csr_wen = 1'b1; fires(1, 0, 0, 0); tick();  // csrrw
    bus.csr_wen = 1'b0; fires(0, 1, 0, 0); tick();
    fires(0, 0, 0, 0); bus.csr_ren = 1'b1; #1;                                     // csrr in ID
    checks++;
    if (bus.stall_id !== 1'b1) begin
      errors++; $display("FAIL csr_mem: got %b want %b", bus.stall_id, 1'b1);
    end
    fires(0, 0, 1, 0); tick(); fires(0, 0, 0, 0); #1;
    checks++;
    if (bus.stall_id !== 1'b1) begin
      errors++; $display("FAIL csr_wb: got %b want %b", bus.stall_id, 1'b1);
    end
    bus.id_out_valid = 1'b0; #1;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL csr_novalid: got %b want %b", bus.stall_id, 1'b0);
    end
    bus.id_out_valid = 1'b1;
    fires(0, 0, 0, 1); tick(); fires(0, 0, 0, 0); #1;
    checks++;
    if (bus.stall_id !== 1'b0) begin
      errors++; $display("FAIL csr_done: got %b want %b", bus.stall_id, 1'b0);
    end
    bus.csr_ren = 1'b0;
  endtask

  task automatic test_simul_flush();
    set_id(1, 0, 0, 0, 0, 5, 1, 0); fires(1, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 4, 1, 0); fires(1, 1, 0, 0); tick();  // EXE=x4, MEM=x5
    set_id(1, 0, 0, 0, 0, 9, 1, 0); fires(1, 1, 1, 1); bus.flush = 1'b1; tick();
    bus.flush = 1'b0; fires(0, 0, 0, 0);
    set_id(1, 4, 1, 5, 1, 0, 0, 0); #1;  // expect MEM=x4, WB=x5
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b1_10_00) begin
      errors++; $display("FAIL sim_mem_wb: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b1_10_00);
    end
    set_id(1, 9, 1, 0, 0, 0, 0, 0); #1;  // flushed x9 must not exist
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL sim_flush_exe: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
    reset = 1'b0; tick(); reset = 1'b1;
    set_id(1, 4, 1, 5, 1, 0, 0, 0); #1;
    checks++;
    if ({bus.stall_id, bus.forwardA, bus.forwardB} !== 5'b0_00_00) begin
      errors++; $display("FAIL sim_reset_clear: got %b want %b", {bus.stall_id, bus.forwardA, bus.forwardB}, 5'b0_00_00);
    end
  endtask

  task automatic test_random();
    bit haz_a, haz_b, csr_h, exp_stall;
    logic [1:0] fa, fb;
    clr_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      set_id($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
      fires($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.flush           = ($urandom_range(0, 7) == 0);
      bus.csr_ren         = ($urandom_range(0, 3) == 0);
      bus.csr_wen         = ($urandom_range(0, 5) == 0);
      bus.mem_ldata_valid = $urandom_range(0, 1);
      reset               = ($urandom_range(0, 63) != 0);
      #1;
      model_src(bus.rs1_ren, int'(bus.rs1_addr), haz_a, fa);
      model_src(bus.rs2_ren, int'(bus.rs2_addr), haz_b, fb);
      csr_h = bus.csr_ren && (pipe[0].csr || pipe[1].csr || pipe[2].csr);
      exp_stall = bus.id_out_valid && (haz_a || haz_b || csr_h);
      checks++;
      if ({bus.stall_id, bus.forwardA, bus.forwardB} !== {exp_stall, fa, fb}) begin
        errors++;
        $display("FAIL rand_%0d: got %b want %b", n, {bus.stall_id, bus.forwardA, bus.forwardB}, {exp_stall, fa, fb});
      end
      tick();
    end
    reset = 1'b1;
    clr_inputs();
  endtask

`ifdef YSYX_24100006_HAZARD_PERF_EN
  task automatic test_perf();
    clr_inputs();
    reset = 1'b0; tick(); reset = 1'b1;
    set_id(1, 0, 0, 0, 0, 7, 1, 1); fires(1, 0, 0, 0); tick();  // load into EXE
    set_id(1, 7, 1, 0, 0, 0, 0, 0); fires(0, 0, 0, 0);
    repeat (5) tick();                                           // 5 stalled cycles
    drain();
    set_id(1, 0, 0, 0, 0, 5, 1, 0); fires(1, 0, 0, 0); tick();
    set_id(1, 5, 1, 0, 0, 5, 1, 0); fires(1, 1, 1, 1);
    repeat (2) tick();                                           // 2 forwarded issues
    clr_inputs(); #1;
    checks++;
    if (perf_stall_cnt !== 32'd5) begin
      errors++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, 5);
    end
    checks++;
    if (perf_fwd_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_fwd: got %0d want %0d", perf_fwd_cnt, 2);
    end
  endtask
`endif

  initial begin
    clr_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_wb_only();
    test_x0_csr();
    test_simul_flush();
    test_random();
`ifdef YSYX_24100006_HAZARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
